latch_bank_arbiter: RTL and testbench
=====================================

Name: latch_bank_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_W-bit storage register built from D flip-flops.
- Up to NUM_REQ requesters compete for write access.
- A Moore FSM grants one requester, pulses the register enable for one cycle, then acknowledges.
- Sits between requester logic and the shared latch/flip-flop bank, so no two writers ever drive it together.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the stored word and of each requester's data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request; held high until ack.
- d_in  input  NUM_REQ*DATA_W  packed requester data; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant, high in GRANT and WRITE.
- wr_en  output  1  enable pulse to the storage register, high only in WRITE.
- ack  output  NUM_REQ  one-hot completion pulse, high only in DONE.
- q  output  DATA_W  stored word.
- q_bar  output  DATA_W  bitwise inverse of q.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, sampled on the clk edge:
  - state=IDLE, ptr=0, owner=0.
  - gnt=0, ack=0, wr_en=0, busy=0.
  - q=0, q_bar=all ones.
  - Reset mid-transaction aborts it: no write, no ack.
- States: IDLE, GRANT, WRITE, DONE. Outputs are decoded from state and owner, so they are glitch-free registered values.
- IDLE:
  - If req!=0, pick the first set bit scanning from ptr upward, wrapping modulo NUM_REQ.
  - owner <= winner; go to GRANT.
  - Else stay in IDLE.
- GRANT (1 cycle):
  - gnt[owner]=1.
  - If req[owner]=0, the request was withdrawn: go to IDLE, ptr unchanged.
  - Else go to WRITE.
- WRITE (1 cycle):
  - wr_en=1, gnt[owner]=1.
  - q <= d_in slice of owner at the end of this cycle.
  - Next state DONE.
- DONE (1 cycle):
  - ack[owner]=1.
  - ptr <= (owner+1) mod NUM_REQ; go to IDLE.
- Latency from req rising, with the arbiter idle and sampled at edge n:
  - gnt high from n+1.
  - wr_en high at n+2.
  - q valid from n+3.
  - ack high during n+3.
  - Earliest next grant at n+5.
- Throughput: one write per 4 cycles.
- Requesters must hold d_in stable from req rise through ack. A change before WRITE is captured as of the WRITE cycle.
- Requests arriving while busy are only considered at the next IDLE evaluation.
- A requester that still holds req after ack is re-arbitrated fairly, because ptr has moved past it.
- Simultaneous requests: exactly one gnt bit is ever high; gnt, wr_en and ack are never high for two requesters at once.
- Pointer wraps NUM_REQ-1 -> 0.
- q holds its value in every state except WRITE.

Optional Feature:
- Macro ARB_LOCK_EN adds input lock (1 bit).
- With ARB_LOCK_EN: if lock=1 and req[owner]=1 in DONE, the next state is GRANT for the same owner and ptr is not advanced. This gives back-to-back writes every 3 cycles.
- Without ARB_LOCK_EN: the port is absent and DONE always returns to IDLE.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_WRITE=2'd2, ST_DONE=2'd3;
  - default widths.
- One natural sub-module, rr_pick: combinational round-robin priority select taking (req, ptr) and returning the winner index and a valid flag.
- The storage register stays in the top level.

Test Plan:
- Reset, then idle: assert reset 2 cycles -> q=8'h00, q_bar=8'hFF, gnt=0, ack=0, busy=0.
- Single request: req=4'b0100, d_in slice2=8'hA5 -> gnt=4'b0100 at n+1, wr_en at n+2, q=8'hA5 and ack=4'b0100 at n+3, busy low at n+4.
- Contention: req=4'b1111, each slice distinct (11,22,33,44), held until its ack -> grant order 0,1,2,3, then 0 again; q follows 11,22,33,44.
- Withdrawal: req=4'b0010, drop req in GRANT -> no wr_en, no ack, q unchanged, ptr unchanged.
- Reset mid-op: assert reset during WRITE with slice=8'h3C -> q=8'h00 next cycle, no ack, state IDLE.
- ARB_LOCK_EN defined: lock=1, req=4'b0001, other requests pending -> requester 0 writes every 3 cycles until lock drops, then requester 1 is granted.

Source files
------------

// File: rtl/latch_bank_arbiter_pkg.sv
// Shared types and defaults for the latch bank arbiter.
// State encodings are fixed so waveforms and external decoders agree on them.
package latch_bank_arbiter_pkg;

    localparam int unsigned DEFAULT_NUM_REQ = 4;
    localparam int unsigned DEFAULT_DATA_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/latch_bank_arbiter_if.sv
// Requester-side bus of the latch bank arbiter.
// Optional macro ARB_LOCK_EN adds the lock input used for back-to-back writes.
interface latch_bank_arbiter_if
    import latch_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] d_in;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_en;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         q;
    logic [DATA_W-1:0]         q_bar;
    logic                      busy;
`ifdef ARB_LOCK_EN
    logic                      lock;

    modport master (output req, d_in, lock, input gnt, wr_en, ack, q, q_bar, busy);
    modport slave  (input req, d_in, lock, output gnt, wr_en, ack, q, q_bar, busy);
`else
    modport master (output req, d_in, input gnt, wr_en, ack, q, q_bar, busy);
    modport slave  (input req, d_in, output gnt, wr_en, ack, q, q_bar, busy);
`endif

endinterface

// File: rtl/latch_bank_arbiter_rr_pick.sv
// Combinational round-robin select: first set request scanning upward from ptr,
// wrapping modulo NUM_REQ.
module latch_bank_arbiter_rr_pick
    import latch_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned PTR_W   = idx_width(DEFAULT_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] sel;
        idx    = 0;
        sel    = '0;
        valid  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            sel = PTR_W'(idx);
            if (!valid && req[sel]) begin
                valid  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter and write sequencer for one shared storage register.
// Optional macro ARB_LOCK_EN lets the current owner keep the bank for back-to-back writes.
module latch_bank_arbiter
    import latch_bank_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W
) (
    input logic                 clk,
    input logic                 reset,
    latch_bank_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = idx_width(NUM_REQ);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   winner;
    logic               valid;
    logic               hold_owner;
    logic [DATA_W-1:0]  q_q;
    logic [NUM_REQ-1:0] owner_oh;

    latch_bank_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .valid  (valid)
    );

`ifdef ARB_LOCK_EN
    assign hold_owner = bus.lock && bus.req[owner_q];
`else
    assign hold_owner = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    owner_d = winner;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A withdrawn request frees the bank without moving the pointer.
                state_d = bus.req[owner_q] ? ST_WRITE : ST_IDLE;
            end
            ST_WRITE: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (hold_owner) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                    ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            if (state_q == ST_WRITE) begin
                q_q <= bus.d_in[32'(owner_q) * DATA_W +: DATA_W];
            end
        end
    end

    // Outputs decode straight from registered state and owner.
    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign bus.gnt   = (state_q == ST_GRANT || state_q == ST_WRITE) ? owner_oh : '0;
    assign bus.wr_en = (state_q == ST_WRITE);
    assign bus.ack   = (state_q == ST_DONE) ? owner_oh : '0;
    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.q     = q_q;
    assign bus.q_bar = ~q_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed self-checking bench for latch_bank_arbiter (NUM_REQ=4, DATA_W=8).
// The lock scenario is included only when ARB_LOCK_EN is defined.
module tb_latch_bank_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    latch_bank_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    latch_bank_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.d_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.d_in = '0;
        tick();
        tick();
        total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", bus.q); end
        total++; if (bus.q_bar !== 8'hFF) begin
            bad++; $display("FAIL reset_q_bar got=%h want=ff", bus.q_bar);
        end
        total++; if (bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt);
        end
        total++; if (bus.ack !== 4'b0000) begin
            bad++; $display("FAIL reset_ack got=%b want=0000", bus.ack);
        end
        total++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b/%b want=0/0", bus.busy, bus.wr_en);
        end
        reset = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_single();
        do_reset();
        bus.d_in = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req  = 4'b0100;
        tick();
        total++; if (bus.gnt !== 4'b0100 || bus.wr_en !== 1'b0) begin
            bad++; $display("FAIL single_gnt got=%b/%b want=0100/0", bus.gnt, bus.wr_en);
        end
        tick();
        total++; if (bus.wr_en !== 1'b1 || bus.gnt !== 4'b0100) begin
            bad++; $display("FAIL single_wr got=%b/%b want=1/0100", bus.wr_en, bus.gnt);
        end
        tick();
        total++; if (bus.ack !== 4'b0100 || bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL single_ack got=%b/%b want=0100/0000", bus.ack, bus.gnt);
        end
        total++; if (bus.q !== 8'hA5 || bus.q_bar !== 8'h5A) begin
            bad++; $display("FAIL single_q got=%h/%h want=a5/5a", bus.q, bus.q_bar);
        end
        bus.req = '0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0000 || bus.q !== 8'hA5) begin
            bad++; $display("FAIL single_end got=%b/%b/%h want=0/0000/a5", bus.busy, bus.ack, bus.q);
        end
    endtask

    task automatic test_contention();
        int          order [5];
        logic [7:0]  data_tbl [4];
        logic [3:0]  exp_oh;
        order    = '{0, 1, 2, 3, 0};
        data_tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        bus.d_in = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int n;
            n = 0;
            exp_oh = 4'b0001 << order[i];
            tick();
            while (bus.gnt === 4'b0000 && n < 10) begin
                tick();
                n++;
            end
            total++; if (bus.gnt !== exp_oh) begin
                bad++; $display("FAIL contend_gnt%0d got=%b want=%b waited=%0d", i, bus.gnt, exp_oh, n);
            end
            tick();
            total++; if (bus.wr_en !== 1'b1 || bus.gnt !== exp_oh) begin
                bad++; $display("FAIL contend_wr%0d got=%b/%b want=1/%b", i, bus.wr_en, bus.gnt, exp_oh);
            end
            tick();
            total++; if (bus.ack !== exp_oh || bus.q !== data_tbl[order[i]]) begin
                bad++; $display("FAIL contend_ack%0d got=%b/%h want=%b/%h",
                                i, bus.ack, bus.q, exp_oh, data_tbl[order[i]]);
            end
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_withdrawal();
        do_reset();
        // Requester 3 writes first, leaving the pointer at 0 and q at 77.
        bus.d_in = {8'h77, 8'h00, 8'h99, 8'h00};
        bus.req  = 4'b1000;
        tick();
        tick();
        tick();
        bus.req = '0;
        tick();
        bus.req = 4'b0010;
        tick();
        total++; if (bus.gnt !== 4'b0010) begin
            bad++; $display("FAIL withdraw_gnt got=%b want=0010", bus.gnt);
        end
        bus.req = '0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL withdraw_idle got=%b/%b/%b want=0/0/0000",
                            bus.busy, bus.wr_en, bus.gnt);
        end
        tick();
        total++; if (bus.ack !== 4'b0000 || bus.q !== 8'h77) begin
            bad++; $display("FAIL withdraw_q got=%b/%h want=0000/77", bus.ack, bus.q);
        end
        bus.req = 4'b1111;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin
            bad++; $display("FAIL withdraw_ptr got=%b want=0001", bus.gnt);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.d_in = {8'h00, 8'h00, 8'h00, 8'h5A};
        bus.req  = 4'b0001;
        tick();
        tick();
        tick();
        total++; if (bus.q !== 8'h5A) begin bad++; $display("FAIL midop_pre got=%h want=5a", bus.q); end
        bus.req = '0;
        tick();
        bus.d_in = {8'h00, 8'h00, 8'h00, 8'h3C};
        bus.req  = 4'b0001;
        tick();
        tick();
        total++; if (bus.wr_en !== 1'b1) begin
            bad++; $display("FAIL midop_wr got=%b want=1", bus.wr_en);
        end
        reset = 1'b1;
        tick();
        total++; if (bus.q !== 8'h00 || bus.q_bar !== 8'hFF) begin
            bad++; $display("FAIL midop_q got=%h/%h want=00/ff", bus.q, bus.q_bar);
        end
        total++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL midop_state got=%b/%b/%b want=0000/0/0000",
                            bus.ack, bus.busy, bus.gnt);
        end
        reset   = 1'b0;
        bus.req = '0;
        tick();
        total++; if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'h00) begin
            bad++; $display("FAIL midop_after got=%b/%b/%h want=0000/0/00", bus.ack, bus.busy, bus.q);
        end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        bus.lock = 1'b1;
        bus.d_in = {8'h00, 8'h00, 8'hBB, 8'hAA};
        bus.req  = 4'b0011;
        tick();
        total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL lock_g1 got=%b want=0001", bus.gnt); end
        tick();
        total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL lock_w1 got=%b want=1", bus.wr_en); end
        tick();
        total++; if (bus.ack !== 4'b0001 || bus.q !== 8'hAA) begin
            bad++; $display("FAIL lock_a1 got=%b/%h want=0001/aa", bus.ack, bus.q);
        end
        tick();
        total++; if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL lock_g2 got=%b/%b want=0001/1", bus.gnt, bus.busy);
        end
        tick();
        total++; if (bus.wr_en !== 1'b1 || bus.gnt !== 4'b0001) begin
            bad++; $display("FAIL lock_w2 got=%b/%b want=1/0001", bus.wr_en, bus.gnt);
        end
        tick();
        total++; if (bus.ack !== 4'b0001) begin bad++; $display("FAIL lock_a2 got=%b want=0001", bus.ack); end
        bus.lock = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL lock_idle got=%b want=0", bus.busy); end
        tick();
        total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL lock_next got=%b want=0010", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus.req  = '0;
        bus.d_in = '0;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_contention();
        test_withdrawal();
        test_reset_midop();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
